// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcode/state enums and saturation bounds shared by ula_seq
package ula_pkg;

   typedef enum logic [2:0] {
      OP_LOAD    = 3'd0,
      OP_ADD     = 3'd1,
      OP_ADDI    = 3'd2,
      OP_SUB     = 3'd3,
      OP_SUBI    = 3'd4,
      OP_MUL     = 3'd5,
      OP_CLEAR   = 3'd6,
      OP_DISPLAY = 3'd7
   } ula_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } ula_state_t;

   // Bounds are returned wide; callers truncate to 2*WIDTH, which always holds them.
   function automatic logic signed [127:0] sat_max(input int w);
      return (128'sd1 <<< (w - 1)) - 128'sd1;
   endfunction

   function automatic logic signed [127:0] sat_min(input int w);
      return -(128'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/ula_mul_seq.sv
// rtl/ula_mul_seq.sv - iterative signed shift-add multiplier on operand magnitudes
module ula_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [WIDTH-1:0]            a,
   input  logic [WIDTH-1:0]            b,
   output logic                        done,
   output logic signed [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   mag_a, mag_b, mplier;
   logic [2*WIDTH-1:0] mcand, acc;
   logic [CW-1:0]      cnt;
   logic               neg, busy;

   // Magnitudes as unsigned WIDTH-bit values so the most-negative operand still fits.
   assign mag_a = a[WIDTH-1] ? -a : a;
   assign mag_b = b[WIDTH-1] ? -b : b;

   assign product = $signed(neg ? -acc : acc);

   // The start edge performs the first iteration; done pulses after the WIDTH-th.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            acc    <= mag_b[0] ? {{WIDTH{1'b0}}, mag_a} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, mag_a, 1'b0};
            mplier <= mag_b >> 1;
            cnt    <= CW'(1);
            neg    <= a[WIDTH-1] ^ b[WIDTH-1];
            busy   <= 1'b1;
         end else if (busy) begin
            if (mplier[0]) begin
               acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - handshaked ALU with registered result, flags and sequential multiply
// Optional feature macro: ULA_SAT_EN (saturate S on signed overflow).
module ula_seq
   import ula_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       param,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             zf,
   output logic             nf,
   output logic             vf
);

   localparam logic signed [2*WIDTH-1:0] MAXV = (2*WIDTH)'(sat_max(WIDTH));
   localparam logic signed [2*WIDTH-1:0] MINV = (2*WIDTH)'(sat_min(WIDTH));

   ula_state_t                 state;
   ula_op_t                    op;
   logic signed [2*WIDTH-1:0]  a_x, b_x, cmd_v, mul_p, src;
   logic [WIDTH-1:0]           res;
   logic                       ovf, mul_start, mul_done;

   assign op  = ula_op_t'(param);
   assign a_x = {{WIDTH{A[WIDTH-1]}}, A};
   assign b_x = {{WIDTH{B[WIDTH-1]}}, B};

   // True (unwrapped) result of a single-cycle command, wide enough to never overflow.
   always_comb begin
      cmd_v = '0;
      case (op)
         OP_LOAD:          cmd_v = b_x;
         OP_ADD, OP_ADDI:  cmd_v = a_x + b_x;
         OP_SUB, OP_SUBI:  cmd_v = a_x - b_x;
         OP_DISPLAY:       cmd_v = a_x;
         default:          cmd_v = '0;
      endcase
   end

   assign src = (state == ST_BUSY) ? mul_p : cmd_v;
   assign ovf = (src > MAXV) || (src < MINV);

`ifdef ULA_SAT_EN
   assign res = !ovf ? src[WIDTH-1:0]
              : (src[2*WIDTH-1] ? MINV[WIDTH-1:0] : MAXV[WIDTH-1:0]);
`else
   assign res = src[WIDTH-1:0];
`endif

   assign mul_start = (state == ST_IDLE) && in_valid && (op == OP_MUL);

   ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (A),
      .b       (B),
      .done    (mul_done),
      .product (mul_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         S         <= '0;
         zf        <= 1'b0;
         nf        <= 1'b0;
         vf        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (op == OP_MUL) begin
                     state <= ST_BUSY;
                  end else begin
                     S         <= res;
                     zf        <= (res == '0);
                     nf        <= res[WIDTH-1];
                     vf        <= ovf;
                     out_valid <= 1'b1;
                     state     <= ST_HOLD;
                  end
               end
            end
            ST_BUSY: begin
               if (mul_done) begin
                  S         <= res;
                  zf        <= (res == '0);
                  nf        <= res[WIDTH-1];
                  vf        <= ovf;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
